// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: decodes an opcode, drives a one-hot ALU select
// for a per-op number of cycles, then captures the ALU result.
module alu_op_sequencer #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [31:0] alu_chigh,
  input  logic [31:0] alu_clow,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [13:0] op_strobe,
  output logic [31:0] z_high,
  output logic [31:0] z_low,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [13:0] sel;
  logic [13:0] dec_sel;
  logic [3:0]  dec_n;
  logic        dec_ok;
  logic        ill_r;
  logic        last;

  assign last = (cnt == 4'd1);

  // Opcode to one-hot select and EXEC cycle count
  always_comb begin
    dec_sel = '0;
    unique case (opcode)
      5'b00011: dec_sel[0]  = 1'b1;
      5'b00100: dec_sel[1]  = 1'b1;
      5'b01111: dec_sel[2]  = 1'b1;
      5'b10000: dec_sel[3]  = 1'b1;
      5'b01010: dec_sel[4]  = 1'b1;
      5'b01011: dec_sel[5]  = 1'b1;
      5'b00101: dec_sel[6]  = 1'b1;
      5'b00110: dec_sel[7]  = 1'b1;
      5'b00111: dec_sel[8]  = 1'b1;
      5'b01000: dec_sel[9]  = 1'b1;
      5'b01001: dec_sel[10] = 1'b1;
      5'b10001: dec_sel[11] = 1'b1;
      5'b10010: dec_sel[12] = 1'b1;
      5'b11111: dec_sel[13] = 1'b1;
      default:  dec_sel     = '0;
    endcase
    dec_ok = |dec_sel;
    if (dec_sel[2])
      dec_n = 4'(MUL_CYCLES);
    else if (dec_sel[3])
      dec_n = 4'(DIV_CYCLES);
    else
      dec_n = 4'd1;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = dec_ok ? EXEC : DONE;
      end
      EXEC: begin
        if (last)
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Operand latch, cycle counter and result capture
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      alu_a  <= '0;
      alu_b  <= '0;
      z_high <= '0;
      z_low  <= '0;
      cnt    <= '0;
      sel    <= '0;
      ill_r  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ill_r <= start & ~dec_ok;
          if (start && dec_ok) begin
            alu_a <= operand_a;
            alu_b <= operand_b;
            cnt   <= dec_n;
            sel   <= dec_sel;
          end
        end
        EXEC: begin
          if (last) begin
            cnt    <= '0;
            z_low  <= alu_clow;
            z_high <= (sel[2] | sel[3]) ? alu_chigh : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign illegal   = done & ill_r;
  assign op_strobe = (state == EXEC) ? sel : '0;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with a small behavioural
// ALU answering the one-hot select.
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  opcode = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [31:0] alu_chigh;
  logic [31:0] alu_clow;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [13:0] op_strobe;
  logic [31:0] z_high;
  logic [31:0] z_low;
  logic        busy;
  logic        done;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10010;

  alu_op_sequencer dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .opcode    (opcode),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .alu_chigh (alu_chigh),
    .alu_clow  (alu_clow),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .op_strobe (op_strobe),
    .z_high    (z_high),
    .z_low     (z_low),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal)
  );

  always #5 clock = ~clock;

  // Behavioural ALU; unmodelled ops return junk to expose wrong captures
  always_comb begin
    logic [63:0] p;
    p         = 64'(alu_a) * 64'(alu_b);
    alu_chigh = 32'hdeadbeef;
    alu_clow  = 32'h0bad0bad;
    if (op_strobe[0])
      alu_clow = alu_a + alu_b;
    if (op_strobe[2]) begin
      alu_chigh = p[63:32];
      alu_clow  = p[31:0];
    end
    if (op_strobe[3] && alu_b != 0) begin
      alu_chigh = alu_a % alu_b;
      alu_clow  = alu_a / alu_b;
    end
    if (op_strobe[12])
      alu_clow = ~alu_a;
  end

  task automatic test_reset();
    clear = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: got busy=%b done=%b ill=%b want 000",
               busy, done, illegal);
    end
    n_cmp++;
    if ({op_strobe, alu_a, alu_b, z_high, z_low} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got strobe=%h a=%h b=%h zh=%h zl=%h want 0",
               op_strobe, alu_a, alu_b, z_high, z_low);
    end
    clear = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_add();
    opcode = OP_ADD; operand_a = 5; operand_b = 7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n_cmp++;
    if (op_strobe !== 14'h0001 || busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL add_exec: got strobe=%h busy=%b done=%b want 0001 1 0",
               op_strobe, busy, done);
    end
    n_cmp++;
    if (alu_a !== 32'd5 || alu_b !== 32'd7) begin
      n_bad++;
      $display("FAIL add_opnd: got a=%h b=%h want 5 7", alu_a, alu_b);
    end
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b1 || illegal !== 1'b0 || busy !== 1'b1
        || op_strobe !== 14'h0) begin
      n_bad++;
      $display("FAIL add_done: got done=%b ill=%b busy=%b strobe=%h want 1 0 1 0",
               done, illegal, busy, op_strobe);
    end
    n_cmp++;
    if (z_low !== 32'd12 || z_high !== 32'd0) begin
      n_bad++;
      $display("FAIL add_z: got zh=%h zl=%h want 0 c", z_high, z_low);
    end
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL add_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_mul();
    opcode = OP_MUL; operand_a = 32'h10000; operand_b = 32'h10000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (op_strobe !== 14'h0004 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL mul_exec%0d: got strobe=%h done=%b want 0004 0",
                 i, op_strobe, done);
      end
      @(negedge clock);
    end
    n_cmp++;
    if (done !== 1'b1 || z_high !== 32'd1 || z_low !== 32'd0) begin
      n_bad++;
      $display("FAIL mul_done: got done=%b zh=%h zl=%h want 1 1 0",
               done, z_high, z_low);
    end
    @(negedge clock);
  endtask

  task automatic test_illegal();
    opcode = 5'b00000; operand_a = 32'h55; operand_b = 32'h66;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || illegal !== 1'b1 || op_strobe !== 14'h0
        || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL ill_done: got done=%b ill=%b strobe=%h busy=%b want 1 1 0 1",
               done, illegal, op_strobe, busy);
    end
    n_cmp++;
    if (z_high !== 32'd1 || z_low !== 32'd0 || alu_a !== 32'h10000) begin
      n_bad++;
      $display("FAIL ill_hold: got zh=%h zl=%h a=%h want 1 0 10000",
               z_high, z_low, alu_a);
    end
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b0 || illegal !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ill_after: got done=%b ill=%b busy=%b want 0 0 0",
               done, illegal, busy);
    end
  endtask

  task automatic test_div_ignore();
    opcode = OP_DIV; operand_a = 100; operand_b = 7; start = 1'b1;
    @(negedge clock);
    opcode = OP_ADD; operand_a = 1; operand_b = 1;
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (op_strobe !== 14'h0008 || done !== 1'b0 || alu_a !== 32'd100) begin
        n_bad++;
        $display("FAIL div_exec%0d: got strobe=%h done=%b a=%h want 0008 0 64",
                 i, op_strobe, done, alu_a);
      end
      @(negedge clock);
    end
    n_cmp++;
    if (done !== 1'b1 || z_low !== 32'd14 || z_high !== 32'd2) begin
      n_bad++;
      $display("FAIL div_done: got done=%b zh=%h zl=%h want 1 2 e",
               done, z_high, z_low);
    end
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL div_idle: got busy=%b want 0", busy);
    end
    @(negedge clock);
    start = 1'b0;
    n_cmp++;
    if (op_strobe !== 14'h0001 || alu_a !== 32'd1) begin
      n_bad++;
      $display("FAIL div_next: got strobe=%h a=%h want 0001 1",
               op_strobe, alu_a);
    end
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b1 || z_low !== 32'd2 || z_high !== 32'd0) begin
      n_bad++;
      $display("FAIL div_next_done: got done=%b zh=%h zl=%h want 1 0 2",
               done, z_high, z_low);
    end
    @(negedge clock);
  endtask

  task automatic test_clear_mid();
    int seen_done;
    opcode = OP_DIV; operand_a = 50; operand_b = 3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0
        || {op_strobe, alu_a, alu_b, z_high, z_low} !== '0) begin
      n_bad++;
      $display("FAIL clr_now: got busy=%b done=%b strobe=%h a=%h zl=%h want 0",
               busy, done, op_strobe, alu_a, z_low);
    end
    @(negedge clock);
    clear = 1'b1;
    seen_done = 0;
    repeat (4) begin
      @(negedge clock);
      if (done) seen_done++;
    end
    n_cmp++;
    if (seen_done !== 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_nodone: got dones=%0d busy=%b want 0 0",
               seen_done, busy);
    end
    opcode = OP_NOT; operand_a = 0; operand_b = 0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n_cmp++;
    if (op_strobe !== 14'h1000) begin
      n_bad++;
      $display("FAIL not_exec: got strobe=%h want 1000", op_strobe);
    end
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b1 || z_low !== 32'hffffffff || z_high !== 32'd0) begin
      n_bad++;
      $display("FAIL not_done: got done=%b zh=%h zl=%h want 1 0 ffffffff",
               done, z_high, z_low);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [4:0]  codes [14];
    int          hits [14];
    logic [13:0] prev;
    logic [13:0] want;
    int          idx;
    codes = '{5'b00011, 5'b00100, 5'b01111, 5'b10000, 5'b01010,
              5'b01011, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
              5'b01001, 5'b10001, 5'b10010, 5'b11111};
    for (int i = 0; i < 14; i++) hits[i] = 0;
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    idx = 0;
    prev = '0;
    operand_a = 3; operand_b = 4;
    opcode = codes[0];
    start = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      if (op_strobe != 0 && prev == 0) begin
        want = 14'(1) << idx;
        n_cmp++;
        if (op_strobe !== want) begin
          n_bad++;
          $display("FAIL b2b_strobe%0d: got %h want %h", idx, op_strobe, want);
        end
      end
      for (int b = 0; b < 14; b++)
        if (op_strobe[b] && !prev[b]) hits[b]++;
      prev = op_strobe;
      if (done) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_busy%0d: got busy=%b want 1", idx, busy);
        end
        idx++;
        if (idx < 14)
          opcode = codes[idx];
        else
          start = 1'b0;
      end
    end
    start = 1'b0;
    n_cmp++;
    if (idx !== 14) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d dones want 14", idx);
    end
    for (int b = 0; b < 14; b++) begin
      n_cmp++;
      if (hits[b] !== 1) begin
        n_bad++;
        $display("FAIL b2b_hit%0d: got %0d want 1", b, hits[b]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_illegal();
    test_div_ignore();
    test_clear_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 2, sets the number of EXEC cycles for MUL; legal range 1..15.
REQ-002 Parameter DIV_CYCLES, default 4, sets the number of EXEC cycles for DIV; legal range 1..15.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 clear  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request to launch one operation; sampled only in IDLE.
REQ-006 opcode  in  5  operation code: ADD 00011, SUB 00100, MUL 01111, DIV 10000, AND 01010, OR 01011, SHR 00101, SHRA 00110, SHL 00111, ROR 01000, ROL 01001, NEG 10001, NOT 10010, INCPC 11111.
REQ-007 operand_a, operand_b  in  32 each  source operands; sampled with start.
REQ-008 alu_chigh, alu_clow  in  32 each  result halves returned by the ALU.
REQ-009 alu_a, alu_b  out  32 each  registered operands driven to the ALU A and B inputs.
REQ-010 op_strobe  out  14  one-hot ALU select, bit order [0] ADD, [1] SUB, [2] MUL, [3] DIV, [4] AND, [5] OR, [6] SHR, [7] SHRA, [8] SHL, [9] ROR, [10] ROL, [11] NEG, [12] NOT, [13] INCPC.
REQ-011 z_high, z_low  out  32 each  captured result register.
REQ-012 busy  out  1  high while an operation is in progress.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 illegal  out  1  qualifies done: the opcode was unrecognised.

Function
REQ-015 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-016 In IDLE with start=1 and a legal opcode, the block SHALL latch operand_a into alu_a and operand_b into alu_b, load the cycle counter with N, and go to EXEC.
  - N = MUL_CYCLES for MUL, DIV_CYCLES for DIV, 1 for all other opcodes.
REQ-017 In IDLE with start=1 and an illegal opcode, the block SHALL go to DONE with illegal=1; op_strobe SHALL stay 0 and Z SHALL be unchanged.
REQ-018 In EXEC, exactly one op_strobe bit SHALL be high; op_strobe SHALL be all-zero in IDLE and in DONE.
REQ-019 The counter SHALL decrement once per EXEC cycle; on the cycle where it equals 1, the block SHALL capture the ALU result and go to DONE.
  - MUL and DIV: z_high <= alu_chigh and z_low <= alu_clow.
  - All other opcodes: z_high <= 0 and z_low <= alu_clow.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 illegal SHALL be valid only while done=1; it SHALL be 0 at all other times.
REQ-022 busy SHALL be 1 in EXEC and DONE and 0 in IDLE.
REQ-023 Latency SHALL be exactly N+1 cycles from the clock edge that samples start to the cycle in which done=1.
  - An illegal opcode SHALL produce done 1 cycle after start.
REQ-024 start SHALL be ignored while busy=1, with no queuing; opcode and operand changes during EXEC SHALL have no effect.
REQ-025 start held high continuously SHALL launch back-to-back operations, the next one sampled in the IDLE cycle that follows DONE.
REQ-026 alu_a, alu_b, z_high and z_low SHALL hold their values until the next accepted start or the next capture.

Reset
REQ-027 When clear=0, at any time including mid-EXEC, the block SHALL immediately force IDLE with all outputs 0: busy, done, illegal, op_strobe, alu_a, alu_b, z_high, z_low, and the counter.
REQ-028 An operation interrupted by reset SHALL be abandoned: no capture and no done pulse.
REQ-029 After clear returns high, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-030 ADD, operand_a=5, operand_b=7, ALU model returns clow=12 -> op_strobe=0x0001 for 1 cycle, done in the 2nd cycle after start, z_low=12, z_high=0.
REQ-031 MUL with defaults, 0x10000 x 0x10000, ALU returns chigh=1, clow=0 -> op_strobe=0x0004 for 2 cycles, done at cycle 3, z_high=1, z_low=0.
REQ-032 opcode 00000 with start -> done with illegal=1 in the next cycle, op_strobe never nonzero, Z unchanged from its previous value.
REQ-033 DIV started, start re-asserted with ADD during EXEC -> ADD ignored, DIV completes at cycle 5, and only then can a new operation start.
REQ-034 clear pulsed low in the 2nd EXEC cycle of DIV -> all outputs 0 at once, no done pulse, and a subsequent NOT of 0 gives z_low=0xFFFFFFFF.
REQ-035 Reset, then hold start high with opcode rotated through all 14 legal codes -> each op_strobe bit is asserted exactly once, and busy never drops during a DONE cycle.
